id_ex_stage: RTL and testbench

- Decode/issue pipeline stage between the IF/ID instruction latch and the ALU.
- Decodes rs/rt from the current instruction into one-hot read selects that drive the register file's per-register tristate read ports.
- Captures the resulting abus/bbus values, sign-extended immediate, ALU op and one-hot destination select into the ID/EX pipeline register, with stall and flush control.
- Flags RAW dependence on the instruction currently in EX.

---
 rtl/id_ex_stage_if.sv | 32 +++
 rtl/id_ex_stage.sv | 81 ++++++++
 tb/tb_id_ex_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-stage bus bundle, covering the instruction, the register-file
// read ports and the ID/EX pipeline register outputs.
interface id_ex_stage_if #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
);
    logic [31:0]      ibus;
    logic             stall;
    logic             flush;
    logic [WIDTH-1:0] abus_in;
    logic [WIDTH-1:0] bbus_in;
    logic [NREGS-1:0] Aselect;
    logic [NREGS-1:0] Bselect;
    logic [WIDTH-1:0] a_ex;
    logic [WIDTH-1:0] b_ex;
    logic [WIDTH-1:0] imm_ex;
    logic             imm_sel_ex;
    logic [5:0]       op_ex;
    logic [NREGS-1:0] dsel_ex;
    logic             valid_ex;
    logic             raw_hazard;

    modport master (
        output ibus, stall, flush, abus_in, bbus_in,
        input  Aselect, Bselect, a_ex, b_ex, imm_ex, imm_sel_ex, op_ex, dsel_ex, valid_ex, raw_hazard
    );

    modport slave (
        input  ibus, stall, flush, abus_in, bbus_in,
        output Aselect, Bselect, a_ex, b_ex, imm_ex, imm_sel_ex, op_ex, dsel_ex, valid_ex, raw_hazard
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: decodes the instruction into one-hot register-file selects and latches the
// operands into the ID/EX register, with stall, flush and a RAW check against the EX slot.
module id_ex_stage #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input logic clk,
    input logic rst_n,
    id_ex_stage_if.slave bus
);
    localparam logic [NREGS-1:0] ONE = {{(NREGS-1){1'b0}}, 1'b1};

    logic [5:0]       opcode, funct;
    logic [4:0]       rs, rt, rd, dest;
    logic             r_type, imm_sel;
    logic [WIDTH-1:0] imm;
    logic [NREGS-1:0] asel, bsel, dsel;

    logic [WIDTH-1:0] a_d, a_q, b_d, b_q, imm_d, imm_q;
    logic             imm_sel_d, imm_sel_q, valid_d, valid_q;
    logic [5:0]       op_d, op_q;
    logic [NREGS-1:0] dsel_d, dsel_q;

    always_comb begin
        opcode  = bus.ibus[31:26];
        rs      = bus.ibus[25:21];
        rt      = bus.ibus[20:16];
        rd      = bus.ibus[15:11];
        funct   = bus.ibus[5:0];
        r_type  = opcode == 6'd0;
        dest    = r_type ? rd : rt;
        imm_sel = !r_type;
        imm     = {{(WIDTH-16){bus.ibus[15]}}, bus.ibus[15:0]};
        asel    = ONE << rs;
        bsel    = ONE << rt;
        dsel    = ONE << dest;
    end

    // Flush outranks stall: a flushed slot becomes a bubble even while the pipe is held.
    always_comb begin
        a_d       = bus.flush ? '0   : bus.stall ? a_q       : bus.abus_in;
        b_d       = bus.flush ? '0   : bus.stall ? b_q       : bus.bbus_in;
        imm_d     = bus.flush ? '0   : bus.stall ? imm_q     : imm;
        imm_sel_d = bus.flush ? 1'b0 : bus.stall ? imm_sel_q : imm_sel;
        op_d      = bus.flush ? 6'd0 : bus.stall ? op_q      : (r_type ? funct : opcode);
        dsel_d    = bus.flush ? ONE  : bus.stall ? dsel_q    : dsel;
        valid_d   = bus.flush ? 1'b0 : bus.stall ? valid_q   : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            imm_sel_q <= 1'b0;
            op_q      <= 6'd0;
            dsel_q    <= ONE;
            valid_q   <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            imm_sel_q <= imm_sel_d;
            op_q      <= op_d;
            dsel_q    <= dsel_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.Aselect   = asel;
    assign bus.Bselect   = bsel;
    assign bus.a_ex      = a_q;
    assign bus.b_ex      = b_q;
    assign bus.imm_ex    = imm_q;
    assign bus.imm_sel_ex = imm_sel_q;
    assign bus.op_ex     = op_q;
    assign bus.dsel_ex   = dsel_q;
    assign bus.valid_ex  = valid_q;
    // I-type instructions only read through the A port; writes to r0 never create a dependence.
    assign bus.raw_hazard = valid_q & ~dsel_q[0] & (|(dsel_q & (asel | (imm_sel ? '0 : bsel))));
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors with hand-computed expectations for the ID/EX stage.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    id_ex_stage_if #(.WIDTH(32), .NREGS(32)) bus ();

    id_ex_stage #(.WIDTH(32), .NREGS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ib, input logic [31:0] a, input logic [31:0] b);
        bus.ibus    = ib;
        bus.abus_in = a;
        bus.bbus_in = b;
    endtask

    initial begin
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(32'h00A0_0000 | ($urandom & 32'h001F_FFFF), 32'h1234, 32'h5678);
        step();
        step();
        check("rst_dsel", bus.dsel_ex, 32'h1);
        check("rst_valid", {31'd0, bus.valid_ex}, 32'd0);
        check("rst_a", bus.a_ex, 32'd0);
        check("rst_b", bus.b_ex, 32'd0);
        check("rst_imm", bus.imm_ex, 32'd0);
        check("rst_asel", bus.Aselect, 32'h20);
        rst_n = 1'b1;

        drive(32'h0022_1820, 32'd5, 32'd7);
        #1;
        check("r_asel", bus.Aselect, 32'h2);
        check("r_bsel", bus.Bselect, 32'h4);
        step();
        check("r_a", bus.a_ex, 32'd5);
        check("r_b", bus.b_ex, 32'd7);
        check("r_op", {26'd0, bus.op_ex}, 32'h20);
        check("r_dsel", bus.dsel_ex, 32'h8);
        check("r_immsel", {31'd0, bus.imm_sel_ex}, 32'd0);
        check("r_valid", {31'd0, bus.valid_ex}, 32'd1);
        check("r_imm", bus.imm_ex, 32'h0000_1820);

        drive(32'h0060_2820, 32'd0, 32'd0);
        #1 check("haz_a", {31'd0, bus.raw_hazard}, 32'd1);
        drive(32'h0003_2820, 32'd0, 32'd0);
        #1 check("haz_b", {31'd0, bus.raw_hazard}, 32'd1);
        drive(32'h20A3_0001, 32'd0, 32'd0);
        #1 check("haz_itype_rt", {31'd0, bus.raw_hazard}, 32'd0);
        drive(32'h0041_2820, 32'd0, 32'd0);
        #1 check("haz_none", {31'd0, bus.raw_hazard}, 32'd0);

        drive(32'h2024_FFFF, 32'd1, 32'd9);
        step();
        check("i_imm", bus.imm_ex, 32'hFFFF_FFFF);
        check("i_immsel", {31'd0, bus.imm_sel_ex}, 32'd1);
        check("i_op", {26'd0, bus.op_ex}, 32'h08);
        check("i_dsel", bus.dsel_ex, 32'h10);
        check("i_a", bus.a_ex, 32'd1);

        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(32'h0022_1820 + i, 32'd33 + i, 32'd44);
            step();
            check("stall_a", bus.a_ex, 32'd1);
            check("stall_op", {26'd0, bus.op_ex}, 32'h08);
            check("stall_dsel", bus.dsel_ex, 32'h10);
            check("stall_imm", bus.imm_ex, 32'hFFFF_FFFF);
        end
        bus.stall = 1'b0;
        drive(32'h0022_1820, 32'd33, 32'd44);
        step();
        check("unstall_a", bus.a_ex, 32'd33);
        check("unstall_b", bus.b_ex, 32'd44);
        check("unstall_op", {26'd0, bus.op_ex}, 32'h20);
        check("unstall_dsel", bus.dsel_ex, 32'h8);

        bus.stall = 1'b1;
        bus.flush = 1'b1;
        step();
        check("flush_valid", {31'd0, bus.valid_ex}, 32'd0);
        check("flush_dsel", bus.dsel_ex, 32'h1);
        check("flush_a", bus.a_ex, 32'd0);
        check("flush_haz", {31'd0, bus.raw_hazard}, 32'd0);
        bus.stall = 1'b0;
        bus.flush = 1'b0;

        drive(32'h0022_0020, 32'd3, 32'd4);
        step();
        check("r0_dsel", bus.dsel_ex, 32'h1);
        check("r0_valid", {31'd0, bus.valid_ex}, 32'd1);
        drive(32'h0000_0020, 32'd0, 32'd0);
        #1 check("haz_r0", {31'd0, bus.raw_hazard}, 32'd0);

        drive(32'h0022_1820, 32'd5, 32'd7);
        step();
        bus.stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", {31'd0, bus.valid_ex}, 32'd0);
        check("async_dsel", bus.dsel_ex, 32'h1);
        step();
        check("async_hold_a", bus.a_ex, 32'd0);
        rst_n = 1'b1;
        bus.stall = 1'b0;
        step();
        check("post_rst_a", bus.a_ex, 32'd5);
        check("post_rst_dsel", bus.dsel_ex, 32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
